// File: rtl/flash_program_sequencer.sv
// flash_program_sequencer
// Drives the shared FLASH write/command path. Each accepted request becomes a
// JEDEC (AMD-style) command sequence: program word, sector erase, chip erase,
// or a bare F0 reset. Completion is detected by DQ7 data polling. DQ5 and a
// poll-count timeout are error paths, and every error path issues an F0 reset
// write before DONE.
//
// Optional feature: define FLASH_VERIFY_EN to add a read-back verify after a
// successful poll. Program ops compare against CMD_DATA, sector erase against
// FFFF at CMD_ADDR, and chip erase against FFFF at word 0. A verify mismatch
// flags ERROR without issuing F0.
//
// Ports
//   CLK, RESET              clock and synchronous active-high reset
//   CMD_VALID/CMD_READY     request handshake; READY is high only when idle
//   CMD_OP/ADDR/DATA        op (0 prog, 1 sector, 2 chip, 3 reset), address, data
//   DONE/ERROR              1-cycle completion pulse and its error flag
//   BUSY                    high from the cycle after accept through the DONE cycle
//   FLASH_ADDR/DQ_O/DQ_OE   flash address, write data and data driver enable
//   FLASH_DQ_I              flash read data
//   FLASH_WE_n/FLASH_OE_n   flash write and read strobes
module flash_program_sequencer #(
  parameter int ADDR_W    = 20,
  parameter int SETUP_CYC = 2,
  parameter int WE_CYC    = 3,
  parameter int RD_CYC    = 3,
  parameter int TIMEOUT   = 1 << 24
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_OP,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [15:0]       CMD_DATA,
  output logic              DONE,
  output logic              ERROR,
  output logic              BUSY,
  output logic [ADDR_W-1:0] FLASH_ADDR,
  output logic [15:0]       FLASH_DQ_O,
  output logic              FLASH_DQ_OE,
  input  logic [15:0]       FLASH_DQ_I,
  output logic              FLASH_WE_n,
  output logic              FLASH_OE_n
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [1:0] OP_PROG = 2'd0;
  localparam logic [1:0] OP_SECT = 2'd1;
  localparam logic [1:0] OP_CHIP = 2'd2;
  localparam logic [1:0] OP_RST  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_WSETUP, S_WPULSE, S_WHOLD, S_POLL_GAP, S_POLL_RD, S_POLL_CHK,
`ifdef FLASH_VERIFY_EN
    S_VERIFY, S_VERIFY_CHK,
`endif
    S_DONE
  } state_t;

  state_t            state, next_state;
  logic [7:0]        cyc_cnt;
  logic [2:0]        step;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic [15:0]       rd_word;
  logic [CNT_W-1:0]  poll_cnt;
  logic              retry_q, err_q, f0_wr;
  logic              poll_target, poll_met, poll_last, last_write;
  logic              start_f0, set_retry;

  // Address/data of write number idx in the command list for op.
  function automatic logic [ADDR_W+15:0] wr_word(input logic [1:0] op, input logic [2:0] idx,
                                                 input logic [ADDR_W-1:0] addr,
                                                 input logic [15:0] data);
    logic [ADDR_W-1:0] a555, a2aa;
    a555 = ADDR_W'(12'h555);
    a2aa = ADDR_W'(12'h2AA);
    wr_word = {a555, 16'h00AA};
    case (op)
      OP_PROG: case (idx)
        3'd0:    wr_word = {a555, 16'h00AA};
        3'd1:    wr_word = {a2aa, 16'h0055};
        3'd2:    wr_word = {a555, 16'h00A0};
        default: wr_word = {addr, data};
      endcase
      OP_SECT, OP_CHIP: case (idx)
        3'd0, 3'd3: wr_word = {a555, 16'h00AA};
        3'd1, 3'd4: wr_word = {a2aa, 16'h0055};
        3'd2:       wr_word = {a555, 16'h0080};
        default:    wr_word = (op == OP_SECT) ? {addr, 16'h0030} : {a555, 16'h0010};
      endcase
      default: wr_word = {{ADDR_W{1'b0}}, 16'h00F0};
    endcase
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] op);
    case (op)
      OP_PROG: last_idx = 3'd3;
      OP_RST:  last_idx = 3'd0;
      default: last_idx = 3'd5;
    endcase
  endfunction

  // Erase completes with DQ7=1; program completes when DQ7 equals the data bit.
  assign poll_target = (op_q == OP_PROG) ? data_q[7] : 1'b1;
  assign poll_met    = (rd_word[7] == poll_target);
  assign poll_last   = (poll_cnt == CNT_W'(TIMEOUT - 1));
  assign last_write  = f0_wr || (step == last_idx(op_q));

`ifndef FLASH_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^{rd_word[15:8], rd_word[6], rd_word[4:0]};
`endif

  always_comb begin
    next_state  = state;
    start_f0    = 1'b0;
    set_retry   = 1'b0;
    CMD_READY   = 1'b0;
    DONE        = 1'b0;
    ERROR       = 1'b0;
    BUSY        = 1'b1;
    FLASH_WE_n  = 1'b1;
    FLASH_OE_n  = 1'b1;
    FLASH_DQ_OE = 1'b0;
    case (state)
      S_IDLE: begin
        CMD_READY = 1'b1;
        BUSY      = 1'b0;
        if (CMD_VALID) next_state = S_WSETUP;
      end
      S_WSETUP: begin
        FLASH_DQ_OE = 1'b1;
        if (cyc_cnt == 8'(SETUP_CYC - 1)) next_state = S_WPULSE;
      end
      S_WPULSE: begin
        FLASH_DQ_OE = 1'b1;
        FLASH_WE_n  = 1'b0;
        if (cyc_cnt == 8'(WE_CYC - 1)) next_state = S_WHOLD;
      end
      S_WHOLD: begin
        FLASH_DQ_OE = 1'b1;
        if (!last_write)                   next_state = S_WSETUP;
        else if (f0_wr || op_q == OP_RST)  next_state = S_DONE;
        else                               next_state = S_POLL_GAP;
      end
      // Bus turnaround: data driver released before OE_n may fall.
      S_POLL_GAP: next_state = S_POLL_RD;
      S_POLL_RD: begin
        FLASH_OE_n = 1'b0;
        if (cyc_cnt == 8'(RD_CYC - 1)) next_state = S_POLL_CHK;
      end
      // DQ5 grants exactly one re-read; a second miss is a fault.
      S_POLL_CHK: begin
        if (poll_met) begin
`ifdef FLASH_VERIFY_EN
          next_state = S_VERIFY;
`else
          next_state = S_DONE;
`endif
        end else if (retry_q) begin
          start_f0   = 1'b1;
          next_state = S_WSETUP;
        end else if (rd_word[5]) begin
          set_retry  = 1'b1;
          next_state = S_POLL_RD;
        end else if (poll_last) begin
          start_f0   = 1'b1;
          next_state = S_WSETUP;
        end else begin
          next_state = S_POLL_RD;
        end
      end
`ifdef FLASH_VERIFY_EN
      S_VERIFY: begin
        FLASH_OE_n = 1'b0;
        if (cyc_cnt == 8'(RD_CYC - 1)) next_state = S_VERIFY_CHK;
      end
      S_VERIFY_CHK: next_state = S_DONE;
`endif
      S_DONE: begin
        DONE       = 1'b1;
        ERROR      = err_q;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      cyc_cnt    <= '0;
      step       <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_word    <= '0;
      poll_cnt   <= '0;
      retry_q    <= 1'b0;
      err_q      <= 1'b0;
      f0_wr      <= 1'b0;
      FLASH_ADDR <= '0;
      FLASH_DQ_O <= '0;
    end else begin
      state   <= next_state;
      cyc_cnt <= (next_state != state) ? 8'd0 : cyc_cnt + 8'd1;
      case (state)
        S_IDLE: if (CMD_VALID) begin
          op_q     <= CMD_OP;
          addr_q   <= CMD_ADDR;
          data_q   <= CMD_DATA;
          step     <= '0;
          poll_cnt <= '0;
          retry_q  <= 1'b0;
          err_q    <= 1'b0;
          f0_wr    <= 1'b0;
          {FLASH_ADDR, FLASH_DQ_O} <= wr_word(CMD_OP, 3'd0, CMD_ADDR, CMD_DATA);
        end
        S_WHOLD: if (!last_write) begin
          step <= step + 3'd1;
          {FLASH_ADDR, FLASH_DQ_O} <= wr_word(op_q, step + 3'd1, addr_q, data_q);
        end
        S_POLL_RD: if (cyc_cnt == 8'(RD_CYC - 1)) rd_word <= FLASH_DQ_I;
        S_POLL_CHK: begin
          poll_cnt <= poll_cnt + 1'b1;
          if (set_retry) retry_q <= 1'b1;
          if (start_f0) begin
            f0_wr      <= 1'b1;
            err_q      <= 1'b1;
            FLASH_ADDR <= '0;
            FLASH_DQ_O <= 16'h00F0;
          end
`ifdef FLASH_VERIFY_EN
          if (poll_met) FLASH_ADDR <= (op_q == OP_CHIP) ? '0 : addr_q;
`endif
        end
`ifdef FLASH_VERIFY_EN
        S_VERIFY: if (cyc_cnt == 8'(RD_CYC - 1)) rd_word <= FLASH_DQ_I;
        S_VERIFY_CHK: err_q <= (rd_word != ((op_q == OP_PROG) ? data_q : 16'hFFFF));
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_program_sequencer.sv
`timescale 1ns/1ps
// tb_flash_program_sequencer
// Scoreboard bench: stimulus pushes expected flash writes and expected
// completions into queues; a negedge monitor pops and compares whenever the
// DUT issues a write strobe or pulses DONE. Two DUT instances are used: one
// with the default timeout, one with TIMEOUT=64 for the timeout case.
module tb_flash_program_sequencer;

`ifdef FLASH_VERIFY_EN
  localparam int VX = 1;
`else
  localparam int VX = 0;
`endif

  typedef struct packed { logic [19:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic err; logic [31:0] reads; } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_to;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_data;
  logic [15:0] dq_i;

  logic a_ready, a_done, a_err, a_busy, a_dqoe, a_we, a_oe;
  logic b_ready, b_done, b_err, b_busy, b_dqoe, b_we, b_oe;
  logic [19:0] a_addr, b_addr;
  logic [15:0] a_dqo, b_dqo;

  logic m_ready, m_done, m_err, m_busy, m_dqoe, m_we, m_oe;
  logic [19:0] m_addr;
  logic [15:0] m_dqo;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  wr_t   mon_w;
  done_t mon_d;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int read_cnt = 0;
  int overlap_viol = 0;
  int busy_reads = 0;
  logic [15:0] busy_word = 16'h0000;
  logic [15:0] ready_word = 16'h0000;
  logic [15:0] verify_word = 16'h0000;
  logic prev_we = 1'b1, prev_oe = 1'b1, prev_dqoe = 1'b0, chk_after = 1'b0;
  int n_done = 0;

  always #5 clk = ~clk;

  flash_program_sequencer dut (
    .CLK(clk), .RESET(rst), .CMD_VALID(cmd_valid & ~sel_to), .CMD_READY(a_ready),
    .CMD_OP(cmd_op), .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data),
    .DONE(a_done), .ERROR(a_err), .BUSY(a_busy),
    .FLASH_ADDR(a_addr), .FLASH_DQ_O(a_dqo), .FLASH_DQ_OE(a_dqoe),
    .FLASH_DQ_I(dq_i), .FLASH_WE_n(a_we), .FLASH_OE_n(a_oe)
  );

  flash_program_sequencer #(.TIMEOUT(64)) dut_to (
    .CLK(clk), .RESET(rst), .CMD_VALID(cmd_valid & sel_to), .CMD_READY(b_ready),
    .CMD_OP(cmd_op), .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data),
    .DONE(b_done), .ERROR(b_err), .BUSY(b_busy),
    .FLASH_ADDR(b_addr), .FLASH_DQ_O(b_dqo), .FLASH_DQ_OE(b_dqoe),
    .FLASH_DQ_I(dq_i), .FLASH_WE_n(b_we), .FLASH_OE_n(b_oe)
  );

  assign m_ready = sel_to ? b_ready : a_ready;
  assign m_done  = sel_to ? b_done  : a_done;
  assign m_err   = sel_to ? b_err   : a_err;
  assign m_busy  = sel_to ? b_busy  : a_busy;
  assign m_dqoe  = sel_to ? b_dqoe  : a_dqoe;
  assign m_we    = sel_to ? b_we    : a_we;
  assign m_oe    = sel_to ? b_oe    : a_oe;
  assign m_addr  = sel_to ? b_addr  : a_addr;
  assign m_dqo   = sel_to ? b_dqo   : a_dqo;

  // Flash read model: busy status (DQ6 toggling) for busy_reads reads, then
  // the ready word, then the verify word for any read after that.
  assign dq_i = (read_cnt <= busy_reads) ? (busy_word ^ (read_cnt[0] ? 16'h0040 : 16'h0000))
              : (read_cnt == busy_reads + 1) ? ready_word : verify_word;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: write strobes, DONE pulses, and bus-turnaround rule.
  always @(negedge clk) begin
    if (chk_after) begin
      checkOutput("busy_after_done", 32'(m_busy), 32'd0);
      checkOutput("ready_after_done", 32'(m_ready), 32'd1);
      chk_after = 1'b0;
    end
    if (m_done) begin
      done_cnt++;
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got DONE, expected none");
      end else begin
        mon_d = exp_done.pop_front();
        checkOutput("done_error", 32'(m_err), 32'(mon_d.err));
        checkOutput("done_reads", read_cnt, mon_d.reads);
        checkOutput("done_busy", 32'(m_busy), 32'd1);
        checkOutput("done_ready", 32'(m_ready), 32'd0);
      end
      chk_after = 1'b1;
    end
    if (prev_we && !m_we) begin
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got %h/%h, expected none", m_addr, m_dqo);
      end else begin
        mon_w = exp_wr.pop_front();
        checkOutput("wr_addr", 32'(m_addr), 32'(mon_w.addr));
        checkOutput("wr_data", 32'(m_dqo), 32'(mon_w.data));
      end
    end
    if (prev_oe && !m_oe) read_cnt++;
    if ((m_dqoe && !m_oe) || (prev_dqoe && !m_oe) || (!prev_oe && m_dqoe) || (!m_we && !m_oe))
      overlap_viol++;
    prev_we   = m_we;
    prev_oe   = m_oe;
    prev_dqoe = m_dqoe;
  end

  task automatic setModel(input int br, input logic [15:0] bw, input logic [15:0] rw,
                          input logic [15:0] vw);
    busy_reads  = br;
    busy_word   = bw;
    ready_word  = rw;
    verify_word = vw;
  endtask

  task automatic pushWr(input logic [19:0] a, input logic [15:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic pushProgram(input logic [19:0] a, input logic [15:0] d);
    pushWr(20'h00555, 16'h00AA);
    pushWr(20'h002AA, 16'h0055);
    pushWr(20'h00555, 16'h00A0);
    pushWr(a, d);
  endtask

  task automatic pushEraseHead();
    pushWr(20'h00555, 16'h00AA);
    pushWr(20'h002AA, 16'h0055);
    pushWr(20'h00555, 16'h0080);
    pushWr(20'h00555, 16'h00AA);
    pushWr(20'h002AA, 16'h0055);
  endtask

  task automatic pushDone(input logic err, input int reads);
    exp_done.push_back({err, 32'(reads)});
    n_done++;
  endtask

  // Issue one request; inputs are scrambled right after accept so the DUT
  // must rely on its captured copy.
  task automatic applyStimulus(input logic [1:0] op, input logic [19:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    while (!m_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_ready", 32'(m_ready), 32'd1);
    @(posedge clk);
    #1;
    read_cnt  = 0;
    cmd_valid = 1'b0;
    cmd_addr  = ~a;
    cmd_data  = ~d;
    cmd_op    = ~op;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (done_cnt < n_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", done_cnt, n_done);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int n;
    rst = 1'b1;
    sel_to = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_addr = '0;
    cmd_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(m_ready), 32'd1);
    checkOutput("rst_done", 32'(m_done), 32'd0);
    checkOutput("rst_error", 32'(m_err), 32'd0);
    checkOutput("rst_busy", 32'(m_busy), 32'd0);
    checkOutput("rst_we", 32'(m_we), 32'd1);
    checkOutput("rst_oe", 32'(m_oe), 32'd1);
    checkOutput("rst_dqoe", 32'(m_dqoe), 32'd0);
    checkOutput("rst_addr", 32'(m_addr), 32'd0);
    rst = 1'b0;

    $display("[TB] program 12345/BEEF, busy for 50 polls");
    setModel(50, 16'h0000, 16'hBEEF, 16'hBEEF);
    pushProgram(20'h12345, 16'hBEEF);
    pushDone(1'b0, 51 + VX);
    applyStimulus(2'd0, 20'h12345, 16'hBEEF);
    waitDone(2000);

    $display("[TB] sector erase 40000, ready on poll 1000");
    setModel(999, 16'h0000, 16'hFFFF, 16'hFFFF);
    pushEraseHead();
    pushWr(20'h40000, 16'h0030);
    pushDone(1'b0, 1000 + VX);
    applyStimulus(2'd1, 20'h40000, 16'h5A5A);
    waitDone(10000);

    $display("[TB] chip erase, ready on poll 6");
    setModel(5, 16'h0000, 16'hFFFF, 16'hFFFF);
    pushEraseHead();
    pushWr(20'h00555, 16'h0010);
    pushDone(1'b0, 6 + VX);
    applyStimulus(2'd2, 20'h7FFFF, 16'h0000);
    waitDone(2000);

    $display("[TB] program with DQ5 fault");
    setModel(1_000_000, 16'h0020, 16'hBEEF, 16'hBEEF);
    pushProgram(20'h12345, 16'hBEEF);
    pushWr(20'h00000, 16'h00F0);
    pushDone(1'b1, 2);
    applyStimulus(2'd0, 20'h12345, 16'hBEEF);
    waitDone(2000);

    $display("[TB] timeout after 64 polls");
    sel_to = 1'b1;
    setModel(1_000_000, 16'h0000, 16'h0080, 16'h0080);
    pushProgram(20'h00100, 16'h0080);
    pushWr(20'h00000, 16'h00F0);
    pushDone(1'b1, 64);
    applyStimulus(2'd0, 20'h00100, 16'h0080);
    waitDone(2000);
    sel_to = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset op");
    setModel(0, 16'h0000, 16'h0000, 16'h0000);
    pushWr(20'h00000, 16'h00F0);
    pushDone(1'b0, 0);
    applyStimulus(2'd3, 20'h12345, 16'h1111);
    waitDone(200);

    $display("[TB] reset during third unlock write");
    setModel(5, 16'h0080, 16'h1234, 16'h1234);
    pushWr(20'h00555, 16'h00AA);
    pushWr(20'h002AA, 16'h0055);
    pushWr(20'h00555, 16'h00A0);
    base = wr_cnt;
    applyStimulus(2'd0, 20'h00ABC, 16'h1234);
    n = 0;
    while (wr_cnt < base + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("third_write_seen", wr_cnt - base, 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_we", 32'(m_we), 32'd1);
    checkOutput("abort_dqoe", 32'(m_dqoe), 32'd0);
    checkOutput("abort_busy", 32'(m_busy), 32'd0);
    checkOutput("abort_ready", 32'(m_ready), 32'd1);
    rst = 1'b0;
    pushProgram(20'h00ABC, 16'h1234);
    pushDone(1'b0, 6 + VX);
    applyStimulus(2'd0, 20'h00ABC, 16'h1234);
    waitDone(2000);

`ifdef FLASH_VERIFY_EN
    $display("[TB] program with verify mismatch");
    setModel(3, 16'h0000, 16'hBEEF, 16'hBEEE);
    pushProgram(20'h12345, 16'hBEEF);
    pushDone(1'b1, 5);
    applyStimulus(2'd0, 20'h12345, 16'hBEEF);
    waitDone(2000);
`endif

    checkOutput("wr_queue_empty", exp_wr.size(), 0);
    checkOutput("done_queue_empty", exp_done.size(), 0);
    checkOutput("bus_turnaround", overlap_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
